// File: rtl/cam_subarray_ctrl.sv
// Command sequencer for one CAM subarray: accepts one command at a time, drives the
// subarray port bundle through DRIVE/CAPTURE/UPDATE and returns tag, hit and count.
module cam_subarray_ctrl #(
  parameter int DATA_W = 32,
  parameter int CMP_AW = 10,
  parameter int PPG_AW = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [2:0]        cmd_smode,
  input  logic              cmd_addr_select,
  input  logic [CMP_AW-1:0] cmd_cmp_addr,
  input  logic [PPG_AW-1:0] cmd_ppg_addr,
  input  logic [1:0]        cmd_cmp_data,
  input  logic [1:0]        cmd_ppg_data,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_upd_value,
  input  logic              cmd_dst_sel,
  input  logic [4:0]        cmd_dst_row,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_tag,
  output logic              rsp_hit,
  output logic [5:0]        rsp_count,
  output logic              rsp_err,
  output logic              cam_chip_enable,
  output logic [2:0]        cam_operation_mode,
  output logic              cam_addr_select,
  output logic [CMP_AW-1:0] cam_cmp_addr,
  output logic [PPG_AW-1:0] cam_ppg_addr,
  output logic [1:0]        cam_cmp_data,
  output logic [1:0]        cam_ppg_data,
  output logic [DATA_W-1:0] cam_data_in,
  output logic              cam_update_signal,
  output logic [DATA_W-1:0] cam_tag_in,
  input  logic [DATA_W-1:0] cam_tag_out
);

  localparam logic [2:0] OP_WRITE    = 3'b000;
  localparam logic [2:0] OP_UPDATE   = 3'b001;
  localparam logic [2:0] OP_SRCH_UPD = 3'b111;

  typedef enum logic [2:0] {IDLE, DRIVE, CAPTURE, UPDATE, RESP} state_t;

  state_t state, state_nxt;

  logic              accept;
  logic              smode_bad;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] data_q;
  logic              upd_q;
  logic              dst_sel_q;
  logic [4:0]        dst_row_q;
  logic [5:0]        tag_pop;

  logic              ce_d;
  logic [2:0]        mode_d;
  logic              asel_d;
  logic [CMP_AW-1:0] cmp_addr_d;
  logic [PPG_AW-1:0] ppg_addr_d;
  logic [1:0]        cmp_data_d;
  logic [1:0]        ppg_data_d;
  logic [DATA_W-1:0] data_in_d;
  logic              upd_sig_d;
  logic [DATA_W-1:0] tag_in_d;

  function automatic logic is_search_mode(input logic [2:0] m);
    return (m >= 3'b010) && (m <= 3'b110);
  endfunction

  assign accept    = cmd_valid && (state == IDLE);
  assign smode_bad = (cmd_op == OP_SRCH_UPD) && !is_search_mode(cmd_smode);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = smode_bad ? RESP : DRIVE;
      DRIVE:   state_nxt = (op_q == OP_WRITE || op_q == OP_UPDATE) ? RESP : CAPTURE;
      CAPTURE: state_nxt = (op_q == OP_SRCH_UPD) ? UPDATE : RESP;
      UPDATE:  state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The cam_* bundle is registered, so its next value is prepared on the edge that
  // enters DRIVE or UPDATE; everywhere else only the chip enable drops.
  always_comb begin
    cmd_ready  = (state == IDLE);
    rsp_valid  = (state == RESP);
    ce_d       = 1'b0;
    mode_d     = cam_operation_mode;
    asel_d     = cam_addr_select;
    cmp_addr_d = cam_cmp_addr;
    ppg_addr_d = cam_ppg_addr;
    cmp_data_d = cam_cmp_data;
    ppg_data_d = cam_ppg_data;
    data_in_d  = cam_data_in;
    upd_sig_d  = cam_update_signal;
    tag_in_d   = cam_tag_in;
    if (accept && !smode_bad) begin
      ce_d       = 1'b1;
      mode_d     = (cmd_op == OP_SRCH_UPD) ? cmd_smode : cmd_op;
      asel_d     = cmd_addr_select;
      cmp_addr_d = cmd_cmp_addr;
      ppg_addr_d = cmd_ppg_addr;
      cmp_data_d = cmd_cmp_data;
      ppg_data_d = cmd_ppg_data;
      data_in_d  = cmd_data;
      upd_sig_d  = cmd_upd_value;
      tag_in_d   = (cmd_op == OP_UPDATE) ? cmd_data : '0;
    end else if (state == CAPTURE && op_q == OP_SRCH_UPD) begin
      ce_d      = 1'b1;
      mode_d    = OP_UPDATE;
      asel_d    = dst_sel_q;
      upd_sig_d = upd_q;
      tag_in_d  = cam_tag_out & data_q;
      if (dst_sel_q) ppg_addr_d[2:0] = dst_row_q[2:0];
      else           cmp_addr_d[4:0] = dst_row_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cam_chip_enable    <= 1'b0;
      cam_operation_mode <= '0;
      cam_addr_select    <= 1'b0;
      cam_cmp_addr       <= '0;
      cam_ppg_addr       <= '0;
      cam_cmp_data       <= '0;
      cam_ppg_data       <= '0;
      cam_data_in        <= '0;
      cam_update_signal  <= 1'b0;
      cam_tag_in         <= '0;
    end else begin
      cam_chip_enable    <= ce_d;
      cam_operation_mode <= mode_d;
      cam_addr_select    <= asel_d;
      cam_cmp_addr       <= cmp_addr_d;
      cam_ppg_addr       <= ppg_addr_d;
      cam_cmp_data       <= cmp_data_d;
      cam_ppg_data       <= ppg_data_d;
      cam_data_in        <= data_in_d;
      cam_update_signal  <= upd_sig_d;
      cam_tag_in         <= tag_in_d;
    end
  end

  always_comb begin
    tag_pop = '0;
    for (int i = 0; i < DATA_W; i++) tag_pop = tag_pop + {5'b0, cam_tag_out[i]};
  end

  // Response fields are cleared at accept so write/update/illegal commands report a zero tag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_q      <= '0;
      data_q    <= '0;
      upd_q     <= 1'b0;
      dst_sel_q <= 1'b0;
      dst_row_q <= '0;
      rsp_tag   <= '0;
      rsp_hit   <= 1'b0;
      rsp_count <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      op_q      <= cmd_op;
      data_q    <= cmd_data;
      upd_q     <= cmd_upd_value;
      dst_sel_q <= cmd_dst_sel;
      dst_row_q <= cmd_dst_row;
      rsp_tag   <= '0;
      rsp_hit   <= 1'b0;
      rsp_count <= '0;
      rsp_err   <= smode_bad;
    end else if (state == CAPTURE) begin
      rsp_tag   <= cam_tag_out;
      rsp_hit   <= |cam_tag_out;
      rsp_count <= tag_pop;
    end
  end

endmodule

// File: tb/tb_cam_subarray_ctrl.sv
// Bench for cam_subarray_ctrl: a simple row-store stand-in for the subarray plus a
// transaction-level memory model that predicts tags, latency and update effects.
module tb_cam_subarray_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [2:0]  cmd_smode = '0;
  logic        cmd_addr_select = 1'b0;
  logic [9:0]  cmd_cmp_addr = '0;
  logic [5:0]  cmd_ppg_addr = '0;
  logic [1:0]  cmd_cmp_data = '0;
  logic [1:0]  cmd_ppg_data = '0;
  logic [31:0] cmd_data = '0;
  logic        cmd_upd_value = 1'b0;
  logic        cmd_dst_sel = 1'b0;
  logic [4:0]  cmd_dst_row = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_tag;
  logic        rsp_hit;
  logic [5:0]  rsp_count;
  logic        rsp_err;
  logic        cam_chip_enable;
  logic [2:0]  cam_operation_mode;
  logic        cam_addr_select;
  logic [9:0]  cam_cmp_addr;
  logic [5:0]  cam_ppg_addr;
  logic [1:0]  cam_cmp_data;
  logic [1:0]  cam_ppg_data;
  logic [31:0] cam_data_in;
  logic        cam_update_signal;
  logic [31:0] cam_tag_in;
  logic [31:0] cam_tag_out;

  int errors = 0;
  int checks = 0;
  int mode111_seen = 0;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  smode;
    logic        asel;
    logic [9:0]  cmp_addr;
    logic [5:0]  ppg_addr;
    logic [31:0] data;
    logic        upd;
    logic        dst_sel;
    logic [4:0]  dst_row;
  } cmd_t;

  logic [31:0] stub_cmp [32] = '{default: 32'h0};
  logic [31:0] stub_ppg [8]  = '{default: 32'h0};
  logic [31:0] stub_tag = 32'h0;
  logic [31:0] model_cmp [32] = '{default: 32'h0};
  logic [31:0] model_ppg [8]  = '{default: 32'h0};

  assign cam_tag_out = stub_tag;

  cam_subarray_ctrl dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_smode(cmd_smode),
    .cmd_addr_select(cmd_addr_select), .cmd_cmp_addr(cmd_cmp_addr), .cmd_ppg_addr(cmd_ppg_addr),
    .cmd_cmp_data(cmd_cmp_data), .cmd_ppg_data(cmd_ppg_data), .cmd_data(cmd_data),
    .cmd_upd_value(cmd_upd_value), .cmd_dst_sel(cmd_dst_sel), .cmd_dst_row(cmd_dst_row),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag), .rsp_hit(rsp_hit),
    .rsp_count(rsp_count), .rsp_err(rsp_err),
    .cam_chip_enable(cam_chip_enable), .cam_operation_mode(cam_operation_mode),
    .cam_addr_select(cam_addr_select), .cam_cmp_addr(cam_cmp_addr), .cam_ppg_addr(cam_ppg_addr),
    .cam_cmp_data(cam_cmp_data), .cam_ppg_data(cam_ppg_data), .cam_data_in(cam_data_in),
    .cam_update_signal(cam_update_signal), .cam_tag_in(cam_tag_in), .cam_tag_out(cam_tag_out)
  );

  always #5 CLK = ~CLK;

  // Stand-in subarray: row store with a registered tag; a search returns the addressed row.
  always @(posedge CLK) begin
    if (cam_chip_enable === 1'b1) begin
      case (cam_operation_mode)
        3'b000: begin
          if (cam_addr_select) stub_ppg[cam_ppg_addr[2:0]] <= cam_data_in;
          else                 stub_cmp[cam_cmp_addr[4:0]] <= cam_data_in;
        end
        3'b001: begin
          if (cam_addr_select)
            stub_ppg[cam_ppg_addr[2:0]] <= (stub_ppg[cam_ppg_addr[2:0]] & ~cam_tag_in) |
                                           (cam_update_signal ? cam_tag_in : 32'h0);
          else
            stub_cmp[cam_cmp_addr[4:0]] <= (stub_cmp[cam_cmp_addr[4:0]] & ~cam_tag_in) |
                                           (cam_update_signal ? cam_tag_in : 32'h0);
        end
        3'b111: begin
          mode111_seen++;
          stub_tag <= 32'h0;
        end
        default: stub_tag <= cam_addr_select ? stub_ppg[cam_ppg_addr[2:0]] : stub_cmp[cam_cmp_addr[4:0]];
      endcase
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] model_read(input logic sel, input logic [4:0] row);
    return sel ? model_ppg[row[2:0]] : model_cmp[row];
  endfunction

  task automatic model_write(input logic sel, input logic [4:0] row, input logic [31:0] val);
    if (sel) model_ppg[row[2:0]] = val;
    else     model_cmp[row] = val;
  endtask

  function automatic cmd_t mk_cmd(input logic [2:0] op, input logic [2:0] smode, input logic asel,
                                  input logic [9:0] cmp_addr, input logic [5:0] ppg_addr,
                                  input logic [31:0] data, input logic upd,
                                  input logic dst_sel, input logic [4:0] dst_row);
    cmd_t c;
    c.op = op; c.smode = smode; c.asel = asel; c.cmp_addr = cmp_addr; c.ppg_addr = ppg_addr;
    c.data = data; c.upd = upd; c.dst_sel = dst_sel; c.dst_row = dst_row;
    return c;
  endfunction

  task automatic applyStimulus(input cmd_t c, input int hold);
    logic        illegal;
    logic [4:0]  row;
    logic [31:0] exp_tag, upd_mask, cur;
    logic [2:0]  exp_mode;
    int          exp_n, n, w;

    illegal  = (c.op == 3'd7) && (c.smode < 3'd2 || c.smode > 3'd6);
    row      = c.asel ? {2'b00, c.ppg_addr[2:0]} : c.cmp_addr[4:0];
    exp_mode = (c.op == 3'd7) ? c.smode : c.op;
    exp_tag  = 32'h0;
    upd_mask = 32'h0;
    if (illegal) exp_n = 1;
    else if (c.op == 3'd0) begin
      exp_n = 2;
      model_write(c.asel, row, c.data);
    end else if (c.op == 3'd1) begin
      exp_n = 2;
      cur = model_read(c.asel, row);
      model_write(c.asel, row, c.upd ? (cur | c.data) : (cur & ~c.data));
    end else if (c.op == 3'd7) begin
      exp_n = 4;
      exp_tag  = model_read(c.asel, row);
      upd_mask = exp_tag & c.data;
      cur = model_read(c.dst_sel, c.dst_row);
      model_write(c.dst_sel, c.dst_row, c.upd ? (cur | upd_mask) : (cur & ~upd_mask));
    end else begin
      exp_n = 3;
      exp_tag = model_read(c.asel, row);
    end

    cmd_op = c.op; cmd_smode = c.smode; cmd_addr_select = c.asel;
    cmd_cmp_addr = c.cmp_addr; cmd_ppg_addr = c.ppg_addr; cmd_data = c.data;
    cmd_upd_value = c.upd; cmd_dst_sel = c.dst_sel; cmd_dst_row = c.dst_row;
    cmd_cmp_data = 2'($urandom); cmd_ppg_data = 2'($urandom);
    rsp_ready = (hold == 0);
    cmd_valid = 1'b1;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 10) begin
      @(posedge CLK); #1; w++;
    end
    checkOutput("accept_ready", 32'(cmd_ready), 32'h1);
    @(posedge CLK); #1;
    cmd_valid = 1'b0;

    n = 1;
    while (1) begin
      if (!illegal && n == 1) begin
        checkOutput("drive_ce", 32'(cam_chip_enable), 32'h1);
        checkOutput("drive_mode", 32'(cam_operation_mode), 32'(exp_mode));
      end
      if (illegal || n == 2) checkOutput("ce_low", 32'(cam_chip_enable), 32'h0);
      if (!illegal && c.op == 3'd7 && n == 3) begin
        checkOutput("upd_ce", 32'(cam_chip_enable), 32'h1);
        checkOutput("upd_mode", 32'(cam_operation_mode), 32'h1);
        checkOutput("upd_tag_in", cam_tag_in, upd_mask);
        checkOutput("upd_asel", 32'(cam_addr_select), 32'(c.dst_sel));
        checkOutput("upd_value", 32'(cam_update_signal), 32'(c.upd));
        if (c.dst_sel) checkOutput("upd_ppg_row", 32'(cam_ppg_addr[2:0]), 32'(c.dst_row[2:0]));
        else           checkOutput("upd_cmp_row", 32'(cam_cmp_addr[4:0]), 32'(c.dst_row));
      end
      if (rsp_valid === 1'b1 || n >= 8) break;
      checkOutput("busy_ready", 32'(cmd_ready), 32'h0);
      @(posedge CLK); #1;
      n++;
    end
    checkOutput("latency", 32'(n), 32'(exp_n));
    checkOutput("rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("rsp_tag", rsp_tag, exp_tag);
    checkOutput("rsp_hit", 32'(rsp_hit), 32'(exp_tag != 32'h0));
    checkOutput("rsp_count", 32'(rsp_count), 32'($countones(exp_tag)));
    checkOutput("rsp_err", 32'(rsp_err), 32'(illegal));
    checkOutput("resp_ce", 32'(cam_chip_enable), 32'h0);

    for (int h = 0; h < hold; h++) begin
      cmd_valid = (h == 1);
      cmd_op = 3'd0; cmd_addr_select = 1'b0; cmd_cmp_addr = 10'd31; cmd_data = 32'hDEADBEEF;
      @(posedge CLK); #1;
      checkOutput("hold_valid", 32'(rsp_valid), 32'h1);
      checkOutput("hold_tag", rsp_tag, exp_tag);
      checkOutput("hold_err", 32'(rsp_err), 32'(illegal));
      checkOutput("hold_ready", 32'(cmd_ready), 32'h0);
      checkOutput("hold_ce", 32'(cam_chip_enable), 32'h0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    checkOutput("back_idle_ready", 32'(cmd_ready), 32'h1);
    checkOutput("back_idle_valid", 32'(rsp_valid), 32'h0);
  endtask

  initial begin
    cmd_t c;
    #2;
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("rst_rsp_tag", rsp_tag, 32'h0);
    checkOutput("rst_rsp_count", 32'(rsp_count), 32'h0);
    checkOutput("rst_rsp_err", 32'(rsp_err), 32'h0);
    checkOutput("rst_ce", 32'(cam_chip_enable), 32'h0);
    checkOutput("rst_mode", 32'(cam_operation_mode), 32'h0);
    checkOutput("rst_tag_in", cam_tag_in, 32'h0);
    checkOutput("rst_data_in", cam_data_in, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;

    applyStimulus(mk_cmd(3'd0, 3'd0, 1'b0, 10'd3, 6'd0, 32'hA5A5A5A5, 1'b0, 1'b0, 5'd0), 0);
    applyStimulus(mk_cmd(3'd2, 3'd0, 1'b0, 10'd3, 6'd0, 32'h0, 1'b0, 1'b0, 5'd0), 0);
    applyStimulus(mk_cmd(3'd1, 3'd0, 1'b1, 10'd0, 6'd2, 32'h0000FFFF, 1'b1, 1'b0, 5'd0), 0);
    applyStimulus(mk_cmd(3'd3, 3'd0, 1'b1, 10'd0, 6'd2, 32'h0, 1'b0, 1'b0, 5'd0), 0);
    applyStimulus(mk_cmd(3'd0, 3'd0, 1'b0, 10'd7, 6'd0, 32'hF0F0F0F0, 1'b0, 1'b0, 5'd0), 0);
    applyStimulus(mk_cmd(3'd0, 3'd0, 1'b1, 10'd0, 6'd5, 32'hFFFFFFFF, 1'b0, 1'b0, 5'd0), 0);
    applyStimulus(mk_cmd(3'd7, 3'd4, 1'b0, 10'd7, 6'd0, 32'hFF00FF00, 1'b0, 1'b1, 5'd5), 0);
    applyStimulus(mk_cmd(3'd3, 3'd0, 1'b1, 10'd0, 6'd5, 32'h0, 1'b0, 1'b0, 5'd0), 0);
    applyStimulus(mk_cmd(3'd7, 3'd1, 1'b0, 10'd7, 6'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 5'd7), 0);
    applyStimulus(mk_cmd(3'd2, 3'd0, 1'b0, 10'd3, 6'd0, 32'h0, 1'b0, 1'b0, 5'd0), 5);
    applyStimulus(mk_cmd(3'd0, 3'd0, 1'b0, 10'd6, 6'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 5'd0), 0);
    applyStimulus(mk_cmd(3'd6, 3'd0, 1'b0, 10'd6, 6'd0, 32'h0, 1'b0, 1'b0, 5'd0), 0);

    // Reset while a write is in DRIVE: the write must never reach the row store.
    cmd_op = 3'd0; cmd_addr_select = 1'b0; cmd_cmp_addr = 10'd3; cmd_data = 32'h12345678;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    checkOutput("rst_mid_pre_ce", 32'(cam_chip_enable), 32'h1);
    #2 RST = 1'b1;
    #1;
    checkOutput("rst_mid_ce", 32'(cam_chip_enable), 32'h0);
    checkOutput("rst_mid_ready", 32'(cmd_ready), 32'h1);
    checkOutput("rst_mid_valid", 32'(rsp_valid), 32'h0);
    checkOutput("rst_mid_data_in", cam_data_in, 32'h0);
    checkOutput("rst_mid_cmp_addr", 32'(cam_cmp_addr), 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    applyStimulus(mk_cmd(3'd2, 3'd0, 1'b0, 10'd3, 6'd0, 32'h0, 1'b0, 1'b0, 5'd0), 0);

    for (int k = 0; k < 40; k++) begin
      c.op       = 3'($urandom_range(0, 7));
      c.smode    = 3'($urandom_range(0, 7));
      c.asel     = 1'($urandom);
      c.cmp_addr = 10'($urandom);
      c.ppg_addr = 6'($urandom);
      c.data     = $urandom;
      c.upd      = 1'($urandom);
      c.dst_sel  = 1'($urandom);
      c.dst_row  = 5'($urandom);
      applyStimulus(c, $urandom_range(0, 2));
    end

    checkOutput("mode111_never_enabled", 32'(mode111_seen), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cam_subarray_ctrl.md
# cam_subarray_ctrl

Command sequencer that drives one CAM subarray's port bundle. It accepts a single command at a time through a valid/ready handshake and runs it on the subarray: write, masked update, one of the five search modes, or a search-then-update. It then returns the match tag, hit flag and match count on a valid/ready response channel. It sits between the associative-processing scheduler and each subarray instance.

## Interface
- DATA_W, 32, row/tag width; fixed at 32 to match the subarray
- CMP_AW, 10, compare-address width (two 5-bit row fields)
- PPG_AW, 6, ppg-address width (two 3-bit row fields)

Ports:
- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  3  000 write, 001 masked update, 010–110 search (value equals subarray mode), 111 search-update
- cmd_smode  in  3  search mode used only when cmd_op = 111
- cmd_addr_select  in  1  0 = cmp row, 1 = ppg row (for write, update and search)
- cmd_cmp_addr  in  10  compare address
- cmd_ppg_addr  in  6  ppg address
- cmd_cmp_data  in  2  compare key bits
- cmd_ppg_data  in  2  ppg key bits
- cmd_data  in  32  write data (op 000); update mask (ops 001 and 111)
- cmd_upd_value  in  1  bit value written under the mask
- cmd_dst_sel  in  1  op 111 update target: 0 = cmp row, 1 = ppg row
- cmd_dst_row  in  5  op 111 target row; [2:0] used when cmd_dst_sel = 1
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_tag  out  32  raw search tag; 0 for write and update
- rsp_hit  out  1  OR-reduction of rsp_tag
- rsp_count  out  6  popcount of rsp_tag, range 0..32
- rsp_err  out  1  illegal cmd_smode; no subarray access took place
- cam_chip_enable  out  1  subarray chip select
- cam_operation_mode  out  3
- cam_addr_select  out  1
- cam_cmp_addr  out  10
- cam_ppg_addr  out  6
- cam_cmp_data  out  2
- cam_ppg_data  out  2
- cam_data_in  out  32
- cam_update_signal  out  1
- cam_tag_in  out  32
- cam_tag_out  in  32  subarray tag; registered inside the subarray, valid the cycle after a search is driven

## Operation
- States: IDLE, DRIVE, CAPTURE, UPDATE, RESP.
- **IDLE**
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, latch every cmd_* field.
  - If cmd_op = 111 and cmd_smode ∉ {010..110}, go to RESP with rsp_err = 1 and tag, hit and count all 0.
  - Otherwise go to DRIVE.
- **DRIVE**
  - Registered cam_* outputs present the latched command and cam_chip_enable = 1.
  - cam_operation_mode = cmd_op, or cmd_smode when cmd_op = 111.
  - cam_tag_in = cmd_data for op 001.
  - Writes and updates then go to RESP; searches go to CAPTURE.
- **CAPTURE**
  - cam_chip_enable = 0.
  - Register cam_tag_out into rsp_tag; compute rsp_hit and rsp_count from it.
  - Op 111 then goes to UPDATE; the search ops go to RESP.
- **UPDATE** (op 111 only)
  - cam_chip_enable = 1, mode 001.
  - cam_tag_in = captured tag & cmd_data; cam_update_signal = cmd_upd_value.
  - cam_addr_select = cmd_dst_sel.
  - cam_cmp_addr[4:0] or cam_ppg_addr[2:0] = cmd_dst_row.
  - Then go to RESP.
- **RESP**
  - rsp_valid = 1; rsp_* held stable until rsp_ready is sampled high, then go to IDLE.
  - cmd_ready = 0 until back in IDLE; one command is in flight at a time.
- Mode 111 is never driven with cam_chip_enable = 1, because the subarray clears its tag on that mode.
- Outside DRIVE and UPDATE: cam_chip_enable = 0 and the other cam_* outputs hold their last values.

## Timing
- Reset values:
  - state IDLE, cmd_ready 1.
  - rsp_valid, rsp_tag, rsp_hit, rsp_count, rsp_err all 0.
  - Every cam_* output 0.
- Reset takes effect asynchronously mid-command: cam_chip_enable falls immediately and any latched command is discarded.
- rsp_valid rises N cycles after the accept edge (rsp_ready held high, accept edge = cycle 0):
  - illegal op 111: N = 1
  - write or update: N = 2
  - search: N = 3
  - search-update: N = 4
- Throughput: the next command is accepted no earlier than the cycle after the response handshake.
- rsp_count is the zero-extended popcount (6 bits); 32 set bits gives 6'd32.
- rsp_valid held with rsp_ready low: the state stays RESP indefinitely and all outputs are stable.
- cmd_valid asserted outside IDLE is ignored (cmd_ready = 0).

## Test plan
- Write 0xA5A5A5A5 to cmp row 3, then search op 010 with cmp_addr = 3 and cmp_data = 1 -> rsp_tag 0xA5A5A5A5, count 16, hit 1, rsp_valid 3 cycles after accept.
- Op 001, ppg row 2, mask 0x0000FFFF, upd_value 1, row previously 0 -> a following op 011 search with ppg_data = 1 returns 0x0000FFFF, count 16.
- Op 111 with smode 100 whose search returns 0xF0F0F0F0, mask 0xFF00FF00, dst ppg row 5, upd_value 0 -> UPDATE drives tag_in 0xF000F000, mode 001, addr_select 1; rsp_tag 0xF0F0F0F0, count 16.
- Op 111 with smode 001 -> rsp_err 1 one cycle after accept, cam_chip_enable never asserted.
- Hold rsp_ready low for 5 cycles during RESP -> rsp_* stable and cmd_ready 0; a cmd_valid pulse during RESP is not accepted.
- Assert RST during DRIVE of a write -> cam_chip_enable 0 in the same cycle, all outputs at reset values, and a later search shows the row unchanged.
